// File: rtl/cond_fork5_sched.sv
// cond_fork5_sched
//
// Produces the five per-branch valid selects for a 5-way conditional-fork
// micropipeline stage. Each token goes either to one branch, picked
// round-robin, or to every eligible branch at once (broadcast). The select
// vector stays frozen until the token has passed the fork. Per-branch
// outstanding counters keep a branch with no credit from being selected.
//
// Optional feature macro: COND_FORK5_SCHED_BCAST_EN
//   defined   - i_bcast=1 on an accepted token selects all eligible branches
//   undefined - i_bcast is ignored and every token is round-robin unicast
//
// Ports
//   clk         clock; all state changes on the rising edge
//   rst         asynchronous active-high reset
//   i_token     pulse: a token is waiting upstream of the fork
//   i_bcast     broadcast request, sampled with an accepted token
//   i_cfg_en    per-branch enable
//   o_ready     scheduler can accept i_token this cycle
//   o_valid     registered select vector to the fork valid0..valid4
//   o_go        select vector is stable; upstream may fire its drive
//   i_launched  pulse: the token has passed the fork
//   i_free      per-branch pulse: that branch has freed one token
//   o_busy      per-branch flag: outstanding count is nonzero
//   o_err       sticky: a free arrived on a branch with count 0
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no token held; accepts i_token when a branch is eligible
// HOLD   | select vector frozen, o_go=1; waiting for i_launched

module cond_fork5_sched #(
    parameter int MAX_OUT = 3,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_token,
    input  logic       i_bcast,
    input  logic [4:0] i_cfg_en,
    output logic       o_ready,
    output logic [4:0] o_valid,
    output logic       o_go,
    input  logic       i_launched,
    input  logic [4:0] i_free,
    output logic [4:0] o_busy,
    output logic       o_err
);

    typedef enum logic {IDLE, HOLD} stateT;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    stateT            state, stateNext;
    logic [CNT_W-1:0] cnt [5];
    logic [4:0]       validQ, validNext;
    logic [2:0]       rrPtr, rrNext;
    logic [2:0]       chosenQ, chosenNext;
    logic             bcastQ, bcastNext;
    logic             bcastEff;
    logic [4:0]       eligible;
    logic [4:0]       uniSel;
    logic [4:0]       selVec;
    logic [2:0]       uniIdx;
    logic [3:0]       scanIdx;
    logic             scanFound;
    logic             launchEv;
    logic [4:0]       incVec;
    logic             errSet;

    always_comb begin
        for (int b = 0; b < 5; b++) begin
            eligible[b] = i_cfg_en[b] && (cnt[b] < MAX_CNT);
        end
    end

    // First eligible branch scanning rrPtr, rrPtr+1, ... modulo 5.
    always_comb begin
        uniIdx    = rrPtr;
        scanFound = 1'b0;
        scanIdx   = 4'd0;
        for (int k = 0; k < 5; k++) begin
            scanIdx = {1'b0, rrPtr} + 4'(k);
            if (scanIdx >= 4'd5) begin
                scanIdx = scanIdx - 4'd5;
            end
            if (!scanFound && eligible[scanIdx[2:0]]) begin
                scanFound = 1'b1;
                uniIdx    = scanIdx[2:0];
            end
        end
        uniSel = 5'b00001 << uniIdx;
    end

`ifdef COND_FORK5_SCHED_BCAST_EN
    assign bcastEff = i_bcast;
    assign selVec   = i_bcast ? eligible : uniSel;
`else
    logic unusedBcast;
    assign unusedBcast = i_bcast;
    assign bcastEff    = 1'b0;
    assign selVec      = uniSel;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            validQ  <= '0;
            rrPtr   <= '0;
            chosenQ <= '0;
            bcastQ  <= 1'b0;
        end else begin
            state   <= stateNext;
            validQ  <= validNext;
            rrPtr   <= rrNext;
            chosenQ <= chosenNext;
            bcastQ  <= bcastNext;
        end
    end

    always_comb begin
        stateNext  = state;
        validNext  = validQ;
        rrNext     = rrPtr;
        chosenNext = chosenQ;
        bcastNext  = bcastQ;
        o_ready    = 1'b0;
        o_go       = 1'b0;
        launchEv   = 1'b0;
        case (state)
            IDLE: begin
                o_ready = |eligible;
                if (i_token && (|eligible)) begin
                    stateNext  = HOLD;
                    validNext  = selVec;
                    chosenNext = uniIdx;
                    bcastNext  = bcastEff;
                end
            end
            HOLD: begin
                o_go = 1'b1;
                if (i_launched) begin
                    launchEv  = 1'b1;
                    stateNext = IDLE;
                    validNext = '0;
                    // Broadcast tokens do not advance the round-robin pointer.
                    if (!bcastQ) begin
                        rrNext = (chosenQ == 3'd4) ? 3'd0 : chosenQ + 3'd1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                validNext = '0;
            end
        endcase
    end

    assign o_valid = validQ;
    assign incVec  = launchEv ? validQ : 5'b00000;

    // A free with no outstanding token is an error, unless a launch on the
    // same branch in the same cycle cancels it out.
    always_comb begin
        errSet = 1'b0;
        for (int b = 0; b < 5; b++) begin
            if (i_free[b] && !incVec[b] && (cnt[b] == '0)) begin
                errSet = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 5; b++) begin
                cnt[b] <= '0;
            end
            o_err <= 1'b0;
        end else begin
            for (int b = 0; b < 5; b++) begin
                if (incVec[b] && !i_free[b]) begin
                    cnt[b] <= cnt[b] + CNT_W'(1);
                end else if (i_free[b] && !incVec[b] && (cnt[b] != '0)) begin
                    cnt[b] <= cnt[b] - CNT_W'(1);
                end
            end
            if (errSet) begin
                o_err <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 5; b++) begin
            o_busy[b] = (cnt[b] != '0);
        end
    end

endmodule

// File: tb/tb_cond_fork5_sched.sv
module tb_cond_fork5_sched;

    localparam int MAX_OUT = 3;
    localparam int CNT_W   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tok;
    logic       bcast;
    logic [4:0] cfg;
    logic       ready;
    logic [4:0] valid;
    logic       go;
    logic       launched;
    logic [4:0] freeV;
    logic [4:0] busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         mCnt [5];
    int         mRr;
    bit         mHold;
    logic [4:0] mValid;
    bit         mBc;
    int         mChosen;
    bit         mErr;

    cond_fork5_sched #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_token(tok), .i_bcast(bcast),
        .i_cfg_en(cfg), .o_ready(ready), .o_valid(valid), .o_go(go),
        .i_launched(launched), .i_free(freeV), .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] modelElig(input logic [4:0] en);
        logic [4:0] e;
        for (int b = 0; b < 5; b++) e[b] = en[b] && (mCnt[b] < MAX_OUT);
        return e;
    endfunction

    function automatic logic modelReady(input logic [4:0] en);
        return !mHold && (modelElig(en) != 5'b0);
    endfunction

    function automatic logic [4:0] modelBusy();
        logic [4:0] v;
        for (int b = 0; b < 5; b++) v[b] = (mCnt[b] != 0);
        return v;
    endfunction

    task automatic modelReset();
        for (int b = 0; b < 5; b++) mCnt[b] = 0;
        mRr = 0; mHold = 0; mValid = 5'b0; mBc = 0; mChosen = 0; mErr = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic modelStep();
        logic [4:0] el;
        bit         rdy;
        bit         useBc;
        logic [4:0] inc;
        el  = modelElig(cfg);
        rdy = modelReady(cfg);
        inc = (mHold && launched) ? mValid : 5'b0;
        for (int b = 0; b < 5; b++) begin
            if (inc[b] && !freeV[b]) mCnt[b]++;
            else if (freeV[b] && !inc[b]) begin
                if (mCnt[b] == 0) mErr = 1;
                else mCnt[b]--;
            end
        end
        if (!mHold) begin
            if (tok && rdy) begin
`ifdef COND_FORK5_SCHED_BCAST_EN
                useBc = bcast;
`else
                useBc = 0;
`endif
                mBc = useBc;
                mHold = 1;
                if (useBc) mValid = el;
                else begin
                    for (int k = 4; k >= 0; k--)
                        if (el[(mRr + k) % 5]) mChosen = (mRr + k) % 5;
                    mValid = 5'b0;
                    mValid[mChosen] = 1'b1;
                end
            end
        end else if (launched) begin
            mHold = 0;
            mValid = 5'b0;
            if (!mBc) mRr = (mChosen + 1) % 5;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        tok = 0; launched = 0; freeV = 5'b0; bcast = 0;
    endtask

    task automatic doReset();
        tok = 0; bcast = 0; launched = 0; freeV = 5'b0;
        rst = 1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        cfg = 5'b11111;
        doReset();
        checks++; if (valid !== 5'b0) begin errors++; $display("FAIL reset_valid got %b want %b", valid, 5'b0); end
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL reset_go got %b want 0", go); end
        checks++; if (busy !== 5'b0) begin errors++; $display("FAIL reset_busy got %b want %b", busy, 5'b0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_en got %b want 1", ready); end
        cfg = 5'b00000;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready_dis got %b want 0", ready); end
    endtask

    task automatic test_round_robin();
        logic [4:0] want;
        cfg = 5'b11111;
        doReset();
        for (int i = 0; i < 5; i++) begin
            tok = 1;
            tick();
            want = 5'b00001 << i;
            checks++; if (valid !== want || go !== 1'b1) begin errors++; $display("FAIL rr_select%0d got valid=%b go=%b want valid=%b go=1", i, valid, go, want); end
            launched = 1;
            tick();
            checks++; if (valid !== 5'b0 || go !== 1'b0) begin errors++; $display("FAIL rr_launch%0d got valid=%b go=%b want 0/0", i, valid, go); end
        end
        checks++; if (busy !== 5'b11111) begin errors++; $display("FAIL rr_busy got %b want %b", busy, 5'b11111); end
        tok = 1;
        tick();
        checks++; if (valid !== 5'b00001) begin errors++; $display("FAIL rr_wrap got %b want %b", valid, 5'b00001); end
        launched = 1;
        tick();
    endtask

    task automatic test_credit_limit();
        cfg = 5'b00001;
        doReset();
        for (int i = 0; i < MAX_OUT; i++) begin
            tok = 1; tick();
            launched = 1; tick();
        end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL credit_ready_full got %b want 0", ready); end
        tok = 1;
        tick();
        checks++; if (go !== 1'b0 || valid !== 5'b0) begin errors++; $display("FAIL credit_ignored got go=%b valid=%b want 0/00000", go, valid); end
        freeV = 5'b00001;
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL credit_ready_freed got %b want 1", ready); end
    endtask

    task automatic test_inc_dec_same();
        cfg = 5'b00100;
        doReset();
        tok = 1; tick();
        launched = 1; tick();
        tok = 1; tick();
        checks++; if (valid !== 5'b00100) begin errors++; $display("FAIL incdec_select got %b want %b", valid, 5'b00100); end
        launched = 1; freeV = 5'b00100;
        tick();
        checks++; if (busy[2] !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL incdec_busy got busy=%b err=%b want busy[2]=1 err=0", busy, err); end
        freeV = 5'b00100;
        tick();
        checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL incdec_drain got %b want busy[2]=0", busy); end
    endtask

    task automatic test_err_sticky();
        cfg = 5'b11111;
        doReset();
        freeV = 5'b01000;
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
        checks++; if (busy !== 5'b0) begin errors++; $display("FAIL err_cnt_floor got %b want %b", busy, 5'b0); end
        tok = 1; tick();
        launched = 1; tick();
        freeV = 5'b00001; tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
        doReset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
    endtask

    task automatic test_bcast();
        logic [4:0] want;
        cfg = 5'b10000;
        doReset();
        for (int i = 0; i < MAX_OUT; i++) begin
            tok = 1; tick();
            launched = 1; tick();
        end
        cfg = 5'b10110; bcast = 1; tok = 1;
        tick();
`ifdef COND_FORK5_SCHED_BCAST_EN
        want = 5'b00110;
`else
        want = 5'b00010;
`endif
        checks++; if (valid !== want || valid !== mValid) begin errors++; $display("FAIL bcast_select got %b want %b", valid, want); end
        launched = 1;
        tick();
        checks++; if (busy !== modelBusy()) begin errors++; $display("FAIL bcast_busy got %b want %b", busy, modelBusy()); end
    endtask

    task automatic test_rst_in_hold();
        cfg = 5'b01000;
        doReset();
        tok = 1; tick();
        launched = 1; tick();
        tok = 1; tick();
        checks++; if (valid !== 5'b01000 || busy !== 5'b01000) begin errors++; $display("FAIL rsthold_pre got valid=%b busy=%b want 01000/01000", valid, busy); end
        #2;
        rst = 1;
        modelReset();
        #1;
        checks++; if (valid !== 5'b0 || go !== 1'b0) begin errors++; $display("FAIL rsthold_async got valid=%b go=%b want 0/0", valid, go); end
        @(posedge clk);
        #1;
        rst = 0;
        checks++; if (busy !== 5'b0) begin errors++; $display("FAIL rsthold_cnt got %b want %b", busy, 5'b0); end
    endtask

    task automatic test_random();
        cfg = 5'b11111;
        doReset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) cfg = 5'($urandom);
            tok   = ($urandom_range(0, 1) == 1);
            bcast = ($urandom_range(0, 1) == 1);
            launched = mHold ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            for (int b = 0; b < 5; b++)
                freeV[b] = (mCnt[b] > 0 || $urandom_range(0, 60) == 0) && ($urandom_range(0, 4) == 0);
            tick();
            checks++;
            if (valid !== mValid || go !== mHold || busy !== modelBusy() || err !== mErr || ready !== modelReady(cfg)) begin
                errors++;
                $display("FAIL random%0d got valid=%b go=%b busy=%b err=%b ready=%b want valid=%b go=%b busy=%b err=%b ready=%b",
                         i, valid, go, busy, err, ready, mValid, mHold, modelBusy(), mErr, modelReady(cfg));
            end
        end
    endtask

    initial begin
        rst = 1; tok = 0; bcast = 0; cfg = 5'b0; launched = 0; freeV = 5'b0;
        modelReset();
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_inc_dec_same();
        test_err_sticky();
        test_bcast();
        test_rst_in_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
